// File: rtl/score_display.sv
// Two-digit hex score display with blink sequences on score change.
// Short blink burst on any change; endless blink for win/lose codes.
module score_display #(
  parameter int         CLKS_PER_SEC = 25000000,
  parameter int         BLINK_COUNT  = 3,
  parameter logic [7:0] WIN_CODE     = 8'hA1,
  parameter logic [7:0] LOSE_CODE    = 8'hEE
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_Score,
  output logic [6:0] o_Seg_Upper,
  output logic [6:0] o_Seg_Lower,
  output logic       o_Busy
);

  localparam int PHASE = CLKS_PER_SEC / 4;
  localparam int CW    = (PHASE > 1) ? $clog2(PHASE) : 1;
  localparam int PW    = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  localparam logic [CW-1:0] PHASE_MAX = CW'(PHASE - 1);
  localparam logic [PW-1:0] PAIR_MAX  = PW'(BLINK_COUNT - 1);
  localparam logic [6:0]    BLANK     = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    FLASH,
    CODE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    score_q;
  logic [CW-1:0] phase_q, phase_d;
  logic [PW-1:0] pair_q, pair_d;
  logic          show_q, show_d;

  logic change;
  logic in_code;
  logic phase_end;
  logic cur_code;
  logic visible;
  logic [6:0] upper_d, lower_d;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = BLANK;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign change    = (i_Score != score_q);
  assign in_code   = (i_Score == WIN_CODE) || (i_Score == LOSE_CODE);
  assign phase_end = (phase_q == PHASE_MAX);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pair_d  = pair_q;
    show_d  = show_q;
    if (change) begin
      phase_d = '0;
      pair_d  = '0;
      if (in_code) begin
        state_d = CODE;
        show_d  = 1'b1;
      end else begin
        state_d = FLASH;
        show_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          phase_d = '0;
          pair_d  = '0;
          show_d  = 1'b1;
        end
        FLASH: begin
          if (phase_end) begin
            phase_d = '0;
            show_d  = ~show_q;
            // a pair completes at the end of its show half
            if (show_q) begin
              if (pair_q == PAIR_MAX) begin
                state_d = IDLE;
                show_d  = 1'b1;
                pair_d  = '0;
              end else begin
                pair_d = pair_q + PW'(1);
              end
            end
          end else begin
            phase_d = phase_q + CW'(1);
          end
        end
        CODE: begin
          if (phase_end) begin
            phase_d = '0;
            show_d  = ~show_q;
          end else begin
            phase_d = phase_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
          pair_d  = '0;
          show_d  = 1'b1;
        end
      endcase
    end
  end

  // Outputs follow the registered state, one clock behind it.
  assign cur_code = (score_q == WIN_CODE) || (score_q == LOSE_CODE);
  assign visible  = (state_q == IDLE) || show_q;

  always_comb begin
    upper_d = BLANK;
    lower_d = BLANK;
    if (visible) begin
      lower_d = hex_seg(score_q[3:0]);
      if ((score_q >= 8'h10) || cur_code) begin
        upper_d = hex_seg(score_q[7:4]);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= IDLE;
      score_q     <= 8'h00;
      phase_q     <= '0;
      pair_q      <= '0;
      show_q      <= 1'b1;
      o_Seg_Upper <= BLANK;
      o_Seg_Lower <= BLANK;
      o_Busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= change ? i_Score : score_q;
      phase_q     <= phase_d;
      pair_q      <= pair_d;
      show_q      <= show_d;
      o_Seg_Upper <= upper_d;
      o_Seg_Lower <= lower_d;
      o_Busy      <= (state_q != IDLE);
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: directed scenarios plus random score changes,
// compared each clock against a time-since-change reference model.
module tb_score_display;

  localparam int         CPS  = 40;
  localparam int         PH   = CPS / 4;
  localparam int         BC   = 3;
  localparam logic [7:0] WIN  = 8'hA1;
  localparam logic [7:0] LOSE = 8'hEE;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [7:0] i_Score = 8'h00;
  logic [6:0] o_Seg_Upper;
  logic [6:0] o_Seg_Lower;
  logic       o_Busy;

  int checks = 0;
  int failures = 0;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // model: mode 0 idle, 1 flash, 2 code; k = edges since the change edge
  int         mode = 0;
  logic [7:0] mscore = 8'h00;
  int         k = 0;

  score_display #(
    .CLKS_PER_SEC(CPS),
    .BLINK_COUNT (BC),
    .WIN_CODE    (WIN),
    .LOSE_CODE   (LOSE)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Score    (i_Score),
    .o_Seg_Upper(o_Seg_Upper),
    .o_Seg_Lower(o_Seg_Lower),
    .o_Busy     (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_code(input logic [7:0] s);
    return (s == WIN) || (s == LOSE);
  endfunction

  task automatic tick(input logic rst, input logic [7:0] sc);
    logic [6:0] eu, el;
    logic       eb;
    bit         shown;
    i_Rst   = rst;
    i_Score = sc;
    @(posedge i_Clk);
    if (rst) begin
      eu = 7'h7F;
      el = 7'h7F;
      eb = 1'b0;
    end else begin
      shown = (mode == 0) ||
              (mode == 1 && ((k / PH) % 2) == 1) ||
              (mode == 2 && ((k / PH) % 2) == 0);
      eb = (mode != 0);
      el = shown ? hex_tab[mscore[3:0]] : 7'h7F;
      eu = (shown && (mscore >= 8'h10 || is_code(mscore)))
           ? hex_tab[mscore[7:4]] : 7'h7F;
    end
    if (rst) begin
      mode   = 0;
      mscore = 8'h00;
      k      = 0;
    end else if (sc != mscore) begin
      mscore = sc;
      k      = 0;
      mode   = is_code(sc) ? 2 : 1;
    end else begin
      k++;
      if (mode == 1 && k == 2 * PH * BC) mode = 0;
    end
    #1;
    check("upper", {1'b0, o_Seg_Upper}, {1'b0, eu});
    check("lower", {1'b0, o_Seg_Lower}, {1'b0, el});
    check("busy", {7'b0, o_Busy}, {7'b0, eb});
  endtask

  task automatic hold(input logic [7:0] sc, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, sc);
  endtask

  initial begin
    logic [7:0] s;
    int         r;
    repeat (3) tick(1'b1, 8'h00);
    hold(8'h00, 20);
    hold(8'h01, 80);
    hold(8'h05, 25);
    hold(8'h18, 80);
    hold(WIN, 220);
    hold(LOSE, 30);
    hold(8'h00, 80);
    hold(8'h33, 15);
    tick(1'b1, 8'h44);
    hold(8'h00, 20);
    hold(WIN, 15);
    hold(LOSE, 25);
    hold(WIN, 12);
    hold(8'h0F, 70);
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: s = 8'h00;
        1: s = 8'($urandom_range(0, 15));
        2: s = WIN;
        3: s = LOSE;
        default: s = 8'($urandom);
      endcase
      if ($urandom_range(0, 14) == 0) tick(1'b1, s);
      hold(s, $urandom_range(1, 90));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 The block SHALL have parameter CLKS_PER_SEC, default 25000000, meaning the clock frequency in Hz; one blink phase is PHASE = CLKS_PER_SEC/4 clocks.
REQ-002 The block SHALL have parameter BLINK_COUNT, default 3, meaning the number of blank/show pairs shown on a score change.
REQ-003 The block SHALL have parameter WIN_CODE, default 8'hA1, meaning the winner code that blinks indefinitely.
REQ-004 The block SHALL have parameter LOSE_CODE, default 8'hEE, meaning the loser code that blinks indefinitely.
REQ-005 The block SHALL have port i_Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port i_Score, input, 8 bits: the score byte from the game state machine (two hex digits).
REQ-008 The block SHALL have port o_Seg_Upper, output, 7 bits: upper-nibble digit segments, bit0=A .. bit6=G, active-low.
REQ-009 The block SHALL have port o_Seg_Lower, output, 7 bits: lower-nibble digit segments, same encoding as o_Seg_Upper.
REQ-010 The block SHALL have port o_Busy, output, 1 bit: high while any blink sequence (FLASH or CODE) is active.

Function
REQ-011 The block SHALL register all outputs; no combinational path from i_Score to any output.
REQ-012 The block SHALL hold register r_Score, the last accepted score, and SHALL treat i_Score != r_Score on any clock as a change event, loading r_Score <= i_Score on that edge.
REQ-013 The block SHALL decode each nibble using the standard active-low hex table, with anchors 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, b->7'h03, d->7'h21, E->7'h06, F->7'h0E.
REQ-014 The block SHALL define blank as 7'h7F; in the show phase the upper digit SHALL be blank when r_Score < 8'h10, except for the code values.
REQ-015 The block SHALL implement states IDLE, FLASH and CODE, with a phase counter 0..PHASE-1, a show/blank phase flag, and a blink-pair counter 0..BLINK_COUNT-1.
REQ-016 IDLE: the block SHALL drive the decoded r_Score steadily with o_Busy=0; on a change event it SHALL go to CODE if the new score equals WIN_CODE or LOSE_CODE, else to FLASH.
REQ-017 FLASH: the block SHALL start in the blank phase, alternate blank/show every PHASE clocks, and return to IDLE after BLINK_COUNT complete pairs, for a duration of 2*PHASE*BLINK_COUNT clocks.
REQ-018 FLASH: the block SHALL return to IDLE showing the score, not blank, and SHALL drive o_Busy=1 throughout FLASH.
REQ-019 CODE: the block SHALL start in the show phase and alternate show/blank every PHASE clocks indefinitely, with o_Busy=1.
REQ-020 A change event during FLASH or CODE SHALL reload r_Score, clear the phase and pair counters, and re-enter FLASH or CODE per REQ-016 on the same edge.
REQ-021 A change event to a non-code value during CODE SHALL go to FLASH; a change from WIN_CODE to LOSE_CODE or vice versa SHALL restart CODE.
REQ-022 The phase counter SHALL wrap from PHASE-1 to 0 and toggle the phase flag on that same edge.
REQ-023 The pair counter SHALL increment on each blank-to-show... show-to-blank completion and SHALL never exceed BLINK_COUNT-1.
REQ-024 The first segment update after a change event SHALL appear on the outputs 1 clock after the edge that loads r_Score.

Reset
REQ-025 While i_Rst=1 at a clock edge: state=IDLE, r_Score=8'h00, counters=0, o_Seg_Upper=o_Seg_Lower=7'h7F, o_Busy=0.
REQ-026 Reset SHALL take priority over all other events, including a mid-FLASH or mid-CODE sequence and a simultaneous change event.
REQ-027 On the first edge after reset release with i_Score=0, the block SHALL drive o_Seg_Lower=7'h40, o_Seg_Upper=7'h7F; if i_Score!=0, a change event SHALL occur per REQ-012.

Verification (CLKS_PER_SEC=40, so PHASE=10; BLINK_COUNT=3)
REQ-028 Scenario: reset, then i_Score=0 held -> Lower=7'h40, Upper=7'h7F, o_Busy=0 indefinitely.
REQ-029 Scenario: i_Score 00->01 -> 10 clocks blank (7'h7F/7'h7F), then 10 clocks Lower=7'h79, repeated 3 times; after 60 clocks in IDLE, o_Busy=0 and 7'h79 steady.
REQ-030 Scenario: i_Score 05->18 at clock 25 of FLASH -> counters restart; Upper=7'h79, Lower=7'h00 show phase first appears 10 clocks later.
REQ-031 Scenario: i_Score=8'hA1 -> Upper=7'h08, Lower=7'h79 for 10 clocks, then blank for 10 clocks, repeating for at least 200 clocks with o_Busy=1.
REQ-032 Scenario: in CODE(EE), i_Score->00 -> FLASH of "0" for 60 clocks, then IDLE.
REQ-033 Scenario: assert i_Rst mid-FLASH together with a score change -> next edge outputs are 7'h7F/7'h7F, o_Busy=0, and r_Score=0.
